// File: rtl/mem_responder.sv
// Word-addressed data memory responder: req/ready handshake, WAIT_CYCLES wait states, range check.
// Build option MEM_ALIGN_CHECK_EN: misaligned requests complete with err=1 and never write.
module mem_responder #(
    parameter int unsigned DEPTH_LOG2  = 8,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);
    localparam int unsigned Depth     = 2 ** DEPTH_LOG2;
    localparam int unsigned CntW      = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [32:0] SpanBytes = 33'(Depth) << 2;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [31:0]       mem_q [Depth];

    logic [31:0]           off;
    logic                  in_range;
    logic                  misaligned;
    logic                  access_ok;
    logic                  do_access;
    logic                  mem_we;
    logic [DEPTH_LOG2-1:0] word_idx;

    assign off      = addr_q - BASE_ADDR;
    assign in_range = (addr_q >= BASE_ADDR) && ({1'b0, off} < SpanBytes);
    assign word_idx = off[DEPTH_LOG2+1:2];

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = (addr_q[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign access_ok = in_range && !misaligned;
    assign do_access = (state_q == StWait) && (cnt_q == '0);
    assign mem_we    = do_access && access_ok && wr_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array is deliberately not reset; a reset aborts the FSM so mem_we cannot fire afterwards.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[word_idx] <= wdata_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = StWait;
                    cnt_d   = CntW'(WAIT_CYCLES);
                end
            end
            StWait: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    state_d = StResp;
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        addr_d  = addr_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if ((state_q == StIdle) && req) begin
            addr_d  = addr;
            wr_d    = wr;
            wdata_d = wdata;
        end
        if (do_access) begin
            rdata_d = (access_ok && !wr_q) ? mem_q[word_idx] : 32'h0;
            err_d   = !access_ok;
        end
    end

    always_comb begin
        ready = (state_q == StResp);
        busy  = (state_q != StIdle);
        rdata = rdata_q;
        err   = err_q;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Word-addressed data memory responder that sits on the far side of the CPU's memory-access path and services read/write requests issued by the multicycle datapath. It replaces the zero-latency memory model with a request/ready handshake, configurable wait states, and range checking. This lets the control unit be exercised against realistic memory latency.

## Interface

Parameters:
- DEPTH_LOG2, 8, log2 of number of 32-bit words stored (DEPTH = 2**DEPTH_LOG2)
- WAIT_CYCLES, 2, wait states inserted before each access (W, ≥0)
- BASE_ADDR, 32'h0000_0000, byte address of word 0

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req  in  1  request valid; requester holds it, addr, wr and wdata stable until ready
- wr  in  1  1 = write, 0 = read
- addr  in  32  byte address
- wdata  in  32  write data
- rdata  out  32  read data, registered, valid while ready=1
- ready  out  1  one-cycle completion pulse
- err  out  1  error flag, valid only while ready=1
- busy  out  1  high whenever the FSM is not in IDLE

## Operation

- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If req=1 at an edge, latch addr, wr and wdata, load cnt=W, and go to WAIT.
- WAIT:
  - If cnt≠0 at an edge, decrement cnt.
  - If cnt=0 at an edge, perform the access using the latched values and go to RESP.
- RESP:
  - ready=1 for exactly one cycle, then return to IDLE.
  - req is ignored in RESP. A new request is accepted only in IDLE.
- Address decode:
  - off = addr − BASE_ADDR (32-bit, unsigned).
  - Address is in range iff addr ≥ BASE_ADDR and off < 4·DEPTH.
  - Word index = off[DEPTH_LOG2+1:2].
- In-range read: rdata ← mem[index], err ← 0.
- In-range write: mem[index] ← wdata, rdata ← 0, err ← 0.
- Out of range, read or write: no array write, rdata ← 0, err ← 1.
- rdata and err hold their last values until the next access completes.
- Storage array is not reset. Contents survive reset; after power-up they are undefined.

## Timing

- Reset values: state IDLE, rdata 0, ready 0, err 0, busy 0, cnt 0.
- Reset is asynchronous. Assertion mid-operation returns the FSM to IDLE immediately.
  - A pending write in WAIT is discarded; the array is untouched.
  - No ready pulse is produced for the aborted request.
- Latency: the accepting edge is E0. The access happens at edge E0+W+1. ready is high during the cycle after that edge.
- With W=0, ready is high in the second cycle after acceptance.
- busy rises the cycle after E0 and falls when RESP exits.
- Back-to-back throughput with req held high: one access per W+3 cycles. The cycle after RESP is IDLE, and the next request is accepted at the end of that cycle.
- No combinational path from any input to any output.

## Configuration

- MEM_ALIGN_CHECK_EN defined:
  - A request with addr[1:0]≠0 completes with err=1 and rdata=0.
  - No array write occurs. Latency is unchanged.
- MEM_ALIGN_CHECK_EN undefined:
  - addr[1:0] is ignored; the access goes to the containing word.
  - Only the range check can raise err.

## Test plan

All scenarios use defaults (W=2, DEPTH_LOG2=8, BASE_ADDR=0) unless noted.

- Reset: drive reset=0 mid-simulation, at arbitrary clock phase -> rdata=0, ready=0, err=0, busy=0 immediately, not at the next edge.
- Write 32'hDEADBEEF to addr 0x10, then read 0x10 -> read returns rdata=32'hDEADBEEF, err=0; each ready pulse is one cycle wide and rises 3 cycles after the accepting edge.
- Read addr 0x400 (beyond 256 words) -> ready with err=1, rdata=0; a subsequent write to 0x400 also errs and leaves word 0 unchanged.
- Write 32'h12345678 to 0x10, then write 32'hCAFEF00D to 0x13 -> with MEM_ALIGN_CHECK_EN: err=1, and reading 0x10 returns 32'h12345678; without: err=0, and reading 0x10 returns 32'hCAFEF00D.
- Write 32'h11111111 to 0x20, start a write of 32'h22222222 to 0x20, pulse reset during WAIT -> busy drops immediately, no ready pulse; reading 0x20 afterwards returns 32'h11111111.
- Hold req=1 across two reads; repeat with W=0 -> ready pulses are 5 cycles apart at W=2 and 3 cycles apart at W=0.
